multi_timer_controller: RTL and testbench
=========================================

MULTI_TIMER_CONTROLLER -- requirements
Module: multi_timer_controller

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..16).
REQ-002 Parameter CNT_W, default 16, counter and load-value width in bits (2..32).
REQ-003 Parameter PRESCALE_W, default 8, prescaler width in bits; used only when TIMER_PRESCALE_EN is defined.
REQ-004 Clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Rst  in  1  reset, synchronous and active-high.
REQ-006 Config_Enable  in  NUM_CH  per-channel arm/run request, level-sensitive.
REQ-007 Reload_Mode  in  NUM_CH  per channel: 0 = one-shot, 1 = auto-reload.
REQ-008 Load_Value  in  NUM_CH*CNT_W  packed per-channel terminal count; channel c occupies bits [c*CNT_W +: CNT_W].
REQ-009 Status_Clear  in  NUM_CH  write-one-to-clear for Timeout_Status.
REQ-010 Prescale_Value  in  PRESCALE_W  tick divider; port exists only with TIMER_PRESCALE_EN.
REQ-011 Timer_Enable  out  NUM_CH  high while the channel is counting.
REQ-012 Timer_TimeOut  out  NUM_CH  one-cycle pulse at terminal count.
REQ-013 Timeout_Status  out  NUM_CH  sticky timeout flag.
REQ-014 Any_TimeOut  out  1  OR-reduction of Timeout_Status.

Function
REQ-015 Each channel SHALL run a 3-state FSM: IDLE, RUN, EXPIRED; Timer_Enable[c] = (state == RUN), registered.
REQ-016 IDLE -> RUN on an edge sampling Config_Enable[c]=1 with Load_Value[c] != 0; the counter loads Load_Value[c].
REQ-017 Config_Enable[c]=1 with Load_Value[c]=0 SHALL keep the channel in IDLE: no Timer_Enable, no timeout.
REQ-018 In RUN the counter SHALL decrement by 1 on each tick; Load_Value is sampled only at load/reload.
REQ-019 The tick with counter == 1 is terminal: Timer_TimeOut[c] is high for exactly the following cycle, and Timeout_Status[c] is set.
REQ-020 One-shot terminal: RUN -> EXPIRED, counter = 0; auto-reload terminal: stay RUN, counter reloads the current Load_Value[c] (reload value 0 -> IDLE after the pulse).
REQ-021 Timing with a tick every cycle: Timer_Enable high for exactly L cycles, and Timer_TimeOut pulses L edges after the arming edge; auto-reload period = L cycles.
REQ-022 EXPIRED holds Timer_Enable=0 until Config_Enable[c]=0, then goes to IDLE; re-arming requires deassert then reassert.
REQ-023 Config_Enable[c]=0 in RUN SHALL go to IDLE next edge, with counter cleared and no pulse, even when that edge is terminal (disable wins).
REQ-024 Status_Clear[c] clears Timeout_Status[c]; a simultaneous set wins over the clear.
REQ-025 Reload_Mode[c] SHALL be sampled at each terminal event; changing it mid-count is legal.
REQ-026 Channels are fully independent; simultaneous timeouts on several channels all pulse in the same cycle.

Reset
REQ-027 Rst=1 at an edge SHALL force every channel to IDLE, and clear counters, Timer_Enable, Timer_TimeOut, Timeout_Status, Any_TimeOut and the prescaler counter; this overrides all other inputs, including mid-count.
REQ-028 The first edge after Rst deasserts SHALL behave as a normal IDLE edge (it can arm).

Configuration
REQ-029 Macro TIMER_PRESCALE_EN defined: a shared PRESCALE_W-bit prescaler produces a one-cycle tick every Prescale_Value+1 cycles, and counters decrement only on tick; terminal detection and reload follow the tick.
REQ-030 Macro TIMER_PRESCALE_EN absent: tick is constant 1, the Prescale_Value port and the prescaler logic are removed, and REQ-021 timing applies exactly.

Structure
REQ-031 Package timer_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2) and the mode constants ONE_SHOT=1'b0, AUTO_RELOAD=1'b1.
REQ-032 One sub-module, timer_channel (FSM, counter, status bit), SHALL be instantiated NUM_CH times via generate; the prescaler and Any_TimeOut stay at top level.

Verification
REQ-033 Ch0 one-shot, L=5, Config_Enable held high -> Timer_Enable high for 5 cycles, Timer_TimeOut[0] pulse on the 5th edge after arming, EXPIRED, Timeout_Status[0]=1, Any_TimeOut=1.
REQ-034 Ch1 auto-reload, L=3, held for 10 cycles -> TimeOut pulses at edges 3, 6, 9; Timer_Enable stays high.
REQ-035 Ch2 L=4, Config_Enable dropped on the terminal edge -> no pulse, IDLE, status stays 0; L=0 -> never enables.
REQ-036 Status_Clear[0] asserted in the same cycle as a new ch0 timeout -> Timeout_Status[0] remains 1; Status_Clear alone on the next edge -> 0.
REQ-037 Rst asserted mid-count on all channels (L=100) -> next cycle all outputs 0; reassert Config_Enable -> full 100-cycle count.
REQ-038 With TIMER_PRESCALE_EN, Prescale_Value=2, L=4 -> Timer_TimeOut 12 cycles (±2 for prescaler phase) after arming.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer: channel FSM states and reload modes.
package timer_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  localparam logic ONE_SHOT    = 1'b0;
  localparam logic AUTO_RELOAD = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/EXPIRED FSM, down-counter, timeout pulse and sticky status bit.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cfg_en,
  input  logic             reload_mode,
  input  logic [CNT_W-1:0] load_value,
  input  logic             status_clear,
  output logic             timer_enable,
  output logic             timeout,
  output logic             status
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             status_q, status_d;
  logic             load_nonzero;

  assign load_nonzero = (load_value != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    status_d  = status_q;
    if (status_clear) begin
      status_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (cfg_en && load_nonzero) begin
          state_d = RUN;
          cnt_d   = load_value;
        end
      end
      RUN: begin
        // Dropping the enable beats a coincident terminal tick.
        if (!cfg_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            timeout_d = 1'b1;
            status_d  = 1'b1;
            if (reload_mode == AUTO_RELOAD && load_nonzero) begin
              cnt_d = load_value;
            end else if (reload_mode == ONE_SHOT) begin
              state_d = EXPIRED;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (!cfg_en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      status_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      status_q  <= status_d;
    end
  end

  assign timer_enable = (state_q == RUN);
  assign timeout      = timeout_q;
  assign status       = status_q;

endmodule

// File: rtl/multi_timer_controller.sv
// NUM_CH independent timers sharing one tick source. Define TIMER_PRESCALE_EN to add the
// Prescale_Value port and a shared prescaler; otherwise every cycle is a tick.
module multi_timer_controller
  import timer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_CH-1:0]       Config_Enable,
  input  logic [NUM_CH-1:0]       Reload_Mode,
  input  logic [NUM_CH*CNT_W-1:0] Load_Value,
  input  logic [NUM_CH-1:0]       Status_Clear,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0]   Prescale_Value,
`endif
  output logic [NUM_CH-1:0]       Timer_Enable,
  output logic [NUM_CH-1:0]       Timer_TimeOut,
  output logic [NUM_CH-1:0]       Timeout_Status,
  output logic                    Any_TimeOut
);

  if (NUM_CH < 1 || NUM_CH > 16 || CNT_W < 2 || CNT_W > 32 || PRESCALE_W < 1) begin : g_bad_params
    $error("multi_timer_controller: parameter out of range");
  end

  logic tick;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc_q, presc_d;

  // Tick on the cycle the counter reaches Prescale_Value, giving a period of Prescale_Value+1.
  always_comb begin
    tick    = (presc_q == Prescale_Value);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    timer_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk          (Clk),
      .rst          (Rst),
      .tick         (tick),
      .cfg_en       (Config_Enable[gi]),
      .reload_mode  (Reload_Mode[gi]),
      .load_value   (Load_Value[gi*CNT_W +: CNT_W]),
      .status_clear (Status_Clear[gi]),
      .timer_enable (Timer_Enable[gi]),
      .timeout      (Timer_TimeOut[gi]),
      .status       (Timeout_Status[gi])
    );
  end

  assign Any_TimeOut = |Timeout_Status;

endmodule

// File: tb/tb_multi_timer_controller.sv
// Directed self-checking bench for multi_timer_controller (default 4 x 16-bit channels).
module tb_multi_timer_controller;
  import timer_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 16;
  localparam int PRESCALE_W = 8;

  logic                    Clk = 1'b0;
  logic                    Rst;
  logic [NUM_CH-1:0]       Config_Enable;
  logic [NUM_CH-1:0]       Reload_Mode;
  logic [NUM_CH*CNT_W-1:0] Load_Value;
  logic [NUM_CH-1:0]       Status_Clear;
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0]   Prescale_Value;
`endif
  logic [NUM_CH-1:0]       Timer_Enable;
  logic [NUM_CH-1:0]       Timer_TimeOut;
  logic [NUM_CH-1:0]       Timeout_Status;
  logic                    Any_TimeOut;

  int n_tests = 0;
  int n_fail  = 0;

  multi_timer_controller #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Config_Enable  (Config_Enable),
    .Reload_Mode    (Reload_Mode),
    .Load_Value     (Load_Value),
    .Status_Clear   (Status_Clear),
`ifdef TIMER_PRESCALE_EN
    .Prescale_Value (Prescale_Value),
`endif
    .Timer_Enable   (Timer_Enable),
    .Timer_TimeOut  (Timer_TimeOut),
    .Timeout_Status (Timeout_Status),
    .Any_TimeOut    (Any_TimeOut)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] %s ok (0x%0h)", tag, got);
    end
  endtask

  task automatic set_load(input int c, input logic [CNT_W-1:0] v);
    Load_Value[c*CNT_W +: CNT_W] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst           = 1'b1;
    Config_Enable = '0;
    Reload_Mode   = '0;
    Load_Value    = '0;
    Status_Clear  = '0;
`ifdef TIMER_PRESCALE_EN
    Prescale_Value = '0;
`endif
    repeat (2) @(negedge Clk);
    check_eq("rst_enable",  32'(Timer_Enable),   32'h0);
    check_eq("rst_timeout", 32'(Timer_TimeOut),  32'h0);
    check_eq("rst_status",  32'(Timeout_Status), 32'h0);
    check_eq("rst_any",     32'(Any_TimeOut),    32'h0);
    Rst = 1'b0;

    // ch0 one-shot, L=5
    set_load(0, 16'd5);
    Config_Enable[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check_eq($sformatf("os_en_e%0d", k), 32'(Timer_Enable[0]), 32'h1);
      check_eq($sformatf("os_to_e%0d", k), 32'(Timer_TimeOut[0]), 32'h0);
    end
    @(negedge Clk);
    check_eq("os_en_e5",     32'(Timer_Enable[0]),   32'h0);
    check_eq("os_to_e5",     32'(Timer_TimeOut[0]),  32'h1);
    check_eq("os_status_e5", 32'(Timeout_Status[0]), 32'h1);
    check_eq("os_any_e5",    32'(Any_TimeOut),       32'h1);
    for (int k = 6; k < 8; k++) begin
      @(negedge Clk);
      check_eq($sformatf("os_expired_en_e%0d", k), 32'(Timer_Enable[0]),  32'h0);
      check_eq($sformatf("os_expired_to_e%0d", k), 32'(Timer_TimeOut[0]), 32'h0);
    end
    Config_Enable[0] = 1'b0;
    @(negedge Clk);
    check_eq("os_status_sticky", 32'(Timeout_Status[0]), 32'h1);

    // ch0 re-armed L=2; clear coincides with the new timeout, then clear alone
    set_load(0, 16'd2);
    Config_Enable[0] = 1'b1;
    @(negedge Clk);
    check_eq("clr_en_e0", 32'(Timer_Enable[0]), 32'h1);
    @(negedge Clk);
    check_eq("clr_en_e1", 32'(Timer_Enable[0]), 32'h1);
    Status_Clear[0] = 1'b1;
    @(negedge Clk);
    check_eq("clr_to_e2",     32'(Timer_TimeOut[0]),  32'h1);
    check_eq("clr_set_wins",  32'(Timeout_Status[0]), 32'h1);
    @(negedge Clk);
    check_eq("clr_alone",     32'(Timeout_Status[0]), 32'h0);
    check_eq("clr_any",       32'(Any_TimeOut),       32'h0);
    Status_Clear[0]  = 1'b0;
    Config_Enable[0] = 1'b0;

    // ch1 auto-reload, L=3, pulses at edges 3, 6, 9
    set_load(1, 16'd3);
    Reload_Mode[1]   = AUTO_RELOAD;
    Config_Enable[1] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge Clk);
      check_eq($sformatf("ar_en_e%0d", k), 32'(Timer_Enable[1]), 32'h1);
      check_eq($sformatf("ar_to_e%0d", k), 32'(Timer_TimeOut[1]),
               32'((k > 0) && (k % 3 == 0)));
    end
    Config_Enable[1] = 1'b0;
    Status_Clear[1]  = 1'b1;
    @(negedge Clk);
    check_eq("ar_disable_en",  32'(Timer_Enable[1]),   32'h0);
    check_eq("ar_disable_to",  32'(Timer_TimeOut[1]),  32'h0);
    check_eq("ar_status_clr",  32'(Timeout_Status[1]), 32'h0);
    Status_Clear[1] = 1'b0;
    Reload_Mode[1]  = ONE_SHOT;

    // ch2 L=4, enable dropped so the terminal edge sees it low
    set_load(2, 16'd4);
    Config_Enable[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check_eq($sformatf("drop_en_e%0d", k), 32'(Timer_Enable[2]), 32'h1);
    end
    Config_Enable[2] = 1'b0;
    @(negedge Clk);
    check_eq("drop_en_e4",     32'(Timer_Enable[2]),   32'h0);
    check_eq("drop_to_e4",     32'(Timer_TimeOut[2]),  32'h0);
    check_eq("drop_status_e4", 32'(Timeout_Status[2]), 32'h0);
    @(negedge Clk);
    check_eq("drop_to_e5",     32'(Timer_TimeOut[2]),  32'h0);

    // ch2 L=0 never enables
    set_load(2, 16'd0);
    Config_Enable[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq($sformatf("zero_en_e%0d", k), 32'(Timer_Enable[2]),  32'h0);
      check_eq($sformatf("zero_to_e%0d", k), 32'(Timer_TimeOut[2]), 32'h0);
    end
    check_eq("zero_status", 32'(Timeout_Status[2]), 32'h0);
    Config_Enable[2] = 1'b0;

    // ch3 armed auto-reload, switched to one-shot mid-count -> expires
    set_load(3, 16'd2);
    Reload_Mode[3]   = AUTO_RELOAD;
    Config_Enable[3] = 1'b1;
    @(negedge Clk);
    check_eq("mode_en_e0", 32'(Timer_Enable[3]), 32'h1);
    Reload_Mode[3] = ONE_SHOT;
    @(negedge Clk);
    check_eq("mode_en_e1", 32'(Timer_Enable[3]),  32'h1);
    check_eq("mode_to_e1", 32'(Timer_TimeOut[3]), 32'h0);
    @(negedge Clk);
    check_eq("mode_to_e2", 32'(Timer_TimeOut[3]), 32'h1);
    check_eq("mode_en_e2", 32'(Timer_Enable[3]),  32'h0);
    Config_Enable[3] = 1'b0;
    @(negedge Clk);

    // All channels L=100, reset mid-count, then a full count with simultaneous timeouts
    for (int c = 0; c < NUM_CH; c++) set_load(c, 16'd100);
    Reload_Mode   = '0;
    Config_Enable = '1;
    repeat (20) @(negedge Clk);
    check_eq("midrst_pre_en", 32'(Timer_Enable), 32'hF);
    Rst = 1'b1;
    @(negedge Clk);
    check_eq("midrst_en",     32'(Timer_Enable),   32'h0);
    check_eq("midrst_to",     32'(Timer_TimeOut),  32'h0);
    check_eq("midrst_status", 32'(Timeout_Status), 32'h0);
    check_eq("midrst_any",    32'(Any_TimeOut),    32'h0);
    Rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      check_eq($sformatf("full_en_e%0d", k), 32'(Timer_Enable), 32'hF);
    end
    @(negedge Clk);
    check_eq("full_to_e100",     32'(Timer_TimeOut),  32'hF);
    check_eq("full_en_e100",     32'(Timer_Enable),   32'h0);
    check_eq("full_status_e100", 32'(Timeout_Status), 32'hF);
    check_eq("full_any_e100",    32'(Any_TimeOut),    32'h1);
    Config_Enable = '0;
    @(negedge Clk);

`ifdef TIMER_PRESCALE_EN
    begin
      int cyc;
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      Prescale_Value = 8'd2;
      set_load(0, 16'd4);
      Config_Enable[0] = 1'b1;
      for (int k = 1; k <= 30 && !seen; k++) begin
        @(negedge Clk);
        if (Timer_TimeOut[0]) begin
          seen = 1'b1;
          cyc  = k;
        end
      end
      check_eq("presc_pulse_seen",     32'(seen), 32'h1);
      check_eq("presc_latency_window", 32'((cyc >= 10) && (cyc <= 14)), 32'h1);
      Config_Enable[0] = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
